// File: rtl/gate_tt_sweeper.sv
// ============================================================================
//  Module   : gate_tt_sweeper
//  Function : Steps a small combinational gate through every input vector and
//             captures its truth table. Optional golden compare: GTS_COMPARE_EN.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module gate_tt_sweeper #(
    parameter int                   N_IN       = 3,
    parameter int                   SETTLE_CYC = 1,
    parameter logic [2**N_IN-1:0]   EXPECT     = 8'h57
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic [N_IN-1:0]     vec_out,
    input  logic                resp_in,
    output logic                busy,
    output logic                done,
    output logic [2**N_IN-1:0]  tt_out,
    output logic                pass
);

    localparam int              c_tt_w        = 2**N_IN;
    localparam logic [1:0]      c_s_idle      = 2'd0;
    localparam logic [1:0]      c_s_settle    = 2'd1;
    localparam logic [1:0]      c_s_sample    = 2'd2;
    localparam logic [1:0]      c_s_done      = 2'd3;
    localparam logic [N_IN-1:0] c_last_idx    = '1;
    localparam logic [3:0]      c_settle_last = 4'(SETTLE_CYC - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic [N_IN-1:0]   r_idx;
    logic [3:0]        r_cnt;
    logic [c_tt_w-1:0] r_shadow;
    logic [c_tt_w-1:0] w_shadow_next;
    logic              w_last_sample;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_s_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_s_idle:   if (start) w_state_next = c_s_settle;
            c_s_settle: if (r_cnt == c_settle_last) w_state_next = c_s_sample;
            c_s_sample: w_state_next = (r_idx == c_last_idx) ? c_s_done : c_s_settle;
            default:    w_state_next = c_s_idle;
        endcase
    end

    // Output decode
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            c_s_settle: busy = 1'b1;
            c_s_sample: busy = 1'b1;
            c_s_done:   done = 1'b1;
            default:    ;
        endcase
    end

    // The final sample and the table publish share one edge, so the published
    // value must already include the bit being sampled.
    always_comb begin
        w_shadow_next        = r_shadow;
        w_shadow_next[r_idx] = resp_in;
    end

    assign w_last_sample = (r_state == c_s_sample) && (r_idx == c_last_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx    <= '0;
            r_cnt    <= '0;
            r_shadow <= '0;
            vec_out  <= '0;
            tt_out   <= '0;
        end else begin
            case (r_state)
                c_s_idle: begin
                    if (start) begin
                        r_shadow <= '0;
                        r_idx    <= '0;
                        vec_out  <= '0;
                        r_cnt    <= '0;
                    end
                end
                c_s_settle: begin
                    if (r_cnt != c_settle_last) r_cnt <= r_cnt + 4'd1;
                end
                c_s_sample: begin
                    r_shadow <= w_shadow_next;
                    if (w_last_sample) begin
                        tt_out <= w_shadow_next;
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                        vec_out <= r_idx + 1'b1;
                        r_cnt   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef GTS_COMPARE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass <= 1'b0;
        end else if (w_last_sample) begin
            pass <= (w_shadow_next == EXPECT);
        end
    end
`else
    assign pass = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gate_tt_sweeper.sv
// ============================================================================
//  Module   : tb_gate_tt_sweeper
//  Function : Directed self-checking bench for gate_tt_sweeper (SETTLE_CYC 1 and 3).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_gate_tt_sweeper;

`ifdef GTS_COMPARE_EN
    localparam logic c_cmp_en = 1'b1;
`else
    localparam logic c_cmp_en = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, start3;
    logic       resp, resp3;
    logic [2:0] vec_out, vec3;
    logic       busy, busy3, done, done3, pass, pass3;
    logic [7:0] tt_out, tt3;
    int         mode;
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    gate_tt_sweeper u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .vec_out(vec_out), .resp_in(resp),
        .busy(busy), .done(done), .tt_out(tt_out), .pass(pass)
    );

    gate_tt_sweeper #(.SETTLE_CYC(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .vec_out(vec3), .resp_in(resp3),
        .busy(busy3), .done(done3), .tt_out(tt3), .pass(pass3)
    );

    // Lab gate x = ~((a|b)&c) with {a,b,c} = vec, or a tied level
    function automatic logic gut(input logic [2:0] v);
        case (mode)
            0:       return ~((v[2] | v[1]) & v[0]);
            1:       return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    always_comb resp  = gut(vec_out);
    always_comb resp3 = gut(vec3);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] vec_of(input int w);
        return (w == 0) ? 32'(vec_out) : 32'(vec3);
    endfunction
    function automatic logic [31:0] tt_of(input int w);
        return (w == 0) ? 32'(tt_out) : 32'(tt3);
    endfunction
    function automatic logic [31:0] done_of(input int w);
        return (w == 0) ? 32'(done) : 32'(done3);
    endfunction
    function automatic logic [31:0] busy_of(input int w);
        return (w == 0) ? 32'(busy) : 32'(busy3);
    endfunction
    function automatic logic [31:0] pass_of(input int w);
        return (w == 0) ? 32'(pass) : 32'(pass3);
    endfunction

    task automatic set_start(input int w, input logic v);
        if (w == 0) start = v;
        else        start3 = v;
    endtask

    // Full sweep: vector n/hold after edge n, done exactly at edge 8*hold
    task automatic sweep(input int w, input int hold, input logic [7:0] exp_tt,
                         input logic [7:0] prev_tt, input logic exp_pass);
        int total;
        total = 8 * hold;
        set_start(w, 1'b1);
        tick();
        set_start(w, 1'b0);
        chk("sweep_busy_start", busy_of(w), 32'd1);
        chk("sweep_vec_start", vec_of(w), 32'd0);
        for (int n = 1; n <= total; n++) begin
            tick();
            if (n < total) begin
                chk("sweep_done_low", done_of(w), 32'd0);
                chk("sweep_busy", busy_of(w), 32'd1);
                chk("sweep_vec", vec_of(w), 32'(n / hold));
                chk("sweep_tt_hold", tt_of(w), 32'(prev_tt));
            end else begin
                chk("sweep_done", done_of(w), 32'd1);
                chk("sweep_busy_end", busy_of(w), 32'd0);
                chk("sweep_tt", tt_of(w), 32'(exp_tt));
                chk("sweep_pass", pass_of(w), 32'(exp_pass));
                chk("sweep_vec_last", vec_of(w), 32'd7);
            end
        end
        tick();
        chk("sweep_done_pulse", done_of(w), 32'd0);
        chk("sweep_vec_hold", vec_of(w), 32'd7);
    endtask

    initial begin
        int dc;
        rst_n  = 1'b0;
        start  = 1'b0;
        start3 = 1'b0;
        mode   = 0;
        repeat (2) tick();
        chk("rst_vec", 32'(vec_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_tt", 32'(tt_out), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_tt3", 32'(tt3), 32'd0);
        rst_n = 1'b1;
        tick();

        // Lab gate table, then tied-high and tied-low responses
        sweep(0, 2, 8'h57, 8'h00, c_cmp_en);
        mode = 1;
        sweep(0, 2, 8'hFF, 8'h57, 1'b0);
        mode = 2;
        sweep(0, 2, 8'h00, 8'hFF, 1'b0);

        // start re-pulsed mid-sweep is ignored
        mode  = 0;
        dc    = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            tick();
            if (done) dc++;
            start = (n == 3 || n == 9);
        end
        chk("repulse_done_count", 32'(dc), 32'd1);
        chk("repulse_tt", 32'(tt_out), 32'h57);
        chk("repulse_pass", 32'(pass), 32'(c_cmp_en));
        chk("repulse_idle", 32'(busy), 32'd0);
        sweep(0, 2, 8'h57, 8'h57, c_cmp_en);

        // Asynchronous abort at +7
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        chk("abort_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_vec", 32'(vec_out), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_tt", 32'(tt_out), 32'd0);
        chk("abort_pass", 32'(pass), 32'd0);
        tick();
        rst_n = 1'b1;
        dc    = 0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (done || busy) dc++;
        end
        chk("abort_no_activity", 32'(dc), 32'd0);
        sweep(0, 2, 8'h57, 8'h00, c_cmp_en);

        // Longer settle time: 4 clocks per vector, done at +32
        mode = 1;
        sweep(1, 4, 8'hFF, 8'h00, 1'b0);
        mode = 0;
        sweep(1, 4, 8'h57, 8'hFF, c_cmp_en);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
